approx_mult_err_monitor: RTL

- Downstream stage of the 8x8 approximate multipliers in the Mult_8X8 library.
- Consumes operand pairs and the approximate 16-bit product, computes the exact product internally, and accumulates error statistics over a programmed number of samples:
  - sum of absolute error distances
  - maximum error distance
  - count of erroneous samples
- Used to characterise any 8x8 approximate multiplier variant in silicon or emulation without host post-processing.

---
 rtl/approx_mult_err_monitor.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/approx_mult_err_monitor.sv
//------------------------------------------------------------------------------
// Module      : approx_mult_err_monitor
// Description : Error-statistics monitor for 8x8 approximate multipliers.
//               Optional signed bias accumulator enabled by ERR_MON_BIAS_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module approx_mult_err_monitor #(
    parameter int CNT_W = 16,
    parameter int ACC_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  n_samples,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        a,
    input  logic [7:0]        b,
    input  logic [15:0]       r_approx,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  sample_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [15:0]       max_err,
    output logic [ACC_W-1:0]  sum_err
`ifdef ERR_MON_BIAS_EN
    ,
    output logic signed [ACC_W-1:0] bias_sum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Sum is widened so a single 16-bit addend can never overflow the check.
    localparam int c_SW = ((ACC_W > 16) ? ACC_W : 16) + 1;
    localparam logic [c_SW-1:0] c_SUM_MAX = {{(c_SW-ACC_W){1'b0}}, {ACC_W{1'b1}}};

    state_t             r_state;
    state_t             w_state_next;
    logic               w_start_run;
    logic               w_hs;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [15:0]        w_prod;
    logic [15:0]        w_ed;
    logic [c_SW-1:0]    w_sum_wide;

    logic [CNT_W-1:0]   r_target;
    logic [CNT_W-1:0]   r_sample_cnt;
    logic [CNT_W-1:0]   r_err_cnt;
    logic [15:0]        r_max_err;
    logic [ACC_W-1:0]   r_sum_err;
    logic               r_v1;
    logic [15:0]        r_exact;
    logic [15:0]        r_approx_q;

    assign in_ready   = (r_state == S_RUN);
    assign busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done       = (r_state == S_DONE);
    assign sample_cnt = r_sample_cnt;
    assign err_cnt    = r_err_cnt;
    assign max_err    = r_max_err;
    assign sum_err    = r_sum_err;

    assign w_hs       = in_valid && in_ready;
    assign w_cnt_next = r_sample_cnt + 1'b1;
    assign w_prod     = {8'd0, a} * {8'd0, b};
    assign w_ed       = (r_exact >= r_approx_q) ? (r_exact - r_approx_q)
                                                : (r_approx_q - r_exact);
    assign w_sum_wide = {{(c_SW-ACC_W){1'b0}}, r_sum_err} + {{(c_SW-16){1'b0}}, w_ed};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start_run  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_next = S_RUN;
                    w_start_run  = 1'b1;
                end
            end
            S_RUN: begin
                if (w_hs && (w_cnt_next == r_target)) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Stage 2 is folded into the statistics update, so an empty
                // stage 1 means every accepted sample has been accounted for.
                if (!r_v1) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_target     <= '0;
            r_sample_cnt <= '0;
            r_err_cnt    <= '0;
            r_max_err    <= '0;
            r_sum_err    <= '0;
            r_v1         <= 1'b0;
            r_exact      <= '0;
            r_approx_q   <= '0;
        end else if (w_start_run) begin
            r_target     <= (n_samples == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : n_samples;
            r_sample_cnt <= '0;
            r_err_cnt    <= '0;
            r_max_err    <= '0;
            r_sum_err    <= '0;
            r_v1         <= 1'b0;
        end else begin
            r_v1 <= w_hs;
            if (w_hs) begin
                r_sample_cnt <= w_cnt_next;
                r_exact      <= w_prod;
                r_approx_q   <= r_approx;
            end
            if (r_v1) begin
                if (w_ed != 16'd0) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
                if (w_ed > r_max_err) begin
                    r_max_err <= w_ed;
                end
                if (w_sum_wide > c_SUM_MAX) begin
                    r_sum_err <= {ACC_W{1'b1}};
                end else begin
                    r_sum_err <= w_sum_wide[ACC_W-1:0];
                end
            end
        end
    end

`ifdef ERR_MON_BIAS_EN
    localparam int c_BW = ((ACC_W > 17) ? ACC_W : 17) + 1;
    localparam logic signed [c_BW-1:0] c_BIAS_MAX = {{(c_BW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [c_BW-1:0] c_BIAS_MIN = {{(c_BW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    logic signed [16:0]      w_diff;
    logic signed [c_BW-1:0]  w_bias_wide;
    logic signed [ACC_W-1:0] r_bias;

    assign w_diff      = $signed({1'b0, r_exact}) - $signed({1'b0, r_approx_q});
    assign w_bias_wide = $signed({{(c_BW-ACC_W){r_bias[ACC_W-1]}}, r_bias})
                       + $signed({{(c_BW-17){w_diff[16]}}, w_diff});
    assign bias_sum    = r_bias;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bias <= '0;
        end else if (w_start_run) begin
            r_bias <= '0;
        end else if (r_v1) begin
            if (w_bias_wide > c_BIAS_MAX) begin
                r_bias <= c_BIAS_MAX[ACC_W-1:0];
            end else if (w_bias_wide < c_BIAS_MIN) begin
                r_bias <= c_BIAS_MIN[ACC_W-1:0];
            end else begin
                r_bias <= w_bias_wide[ACC_W-1:0];
            end
        end
    end
`endif

endmodule

`default_nettype wire
